keycode_fifo_pio: RTL and testbench
===================================

KEYCODE_FIFO_PIO -- requirements
Module: keycode_fifo_pio

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, keycode width; legal range 1..32.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of 2, legal range 2..128.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port address  input  2  Avalon-MM register select.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-007 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  32  Avalon-MM read data, combinational from address, zero wait states.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  FIFO head keycode.
REQ-011 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head.
REQ-013 SHALL have port held_key  output  DATA_WIDTH  last keycode written, level output.
REQ-014 SHALL have port irq  output  1  level interrupt, active-high.

Function
REQ-015 A write is a cycle with chipselect=1 and write_n=0; no other cycle changes register state.
REQ-016 Register map: 0 DATA, 1 STATUS, 2 CONTROL, 3 HELD.
REQ-017 Write to DATA: push writedata[DATA_WIDTH-1:0] into the FIFO and load held_key with the same value, in the same cycle.
REQ-018 Push while full with no pop in that cycle: data dropped, count unchanged, overflow sticky set; held_key still updated.
REQ-019 Pop occurs when out_valid=1 and out_ready=1; head advances on that edge.
REQ-020 Output is first-word-fall-through: out_data valid whenever out_valid=1, no bypass; a push into an empty FIFO raises out_valid on the following cycle.
REQ-021 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop: both performed, count unchanged; allowed when full (no overflow) and when count=1.
REQ-023 Pointers SHALL wrap modulo DEPTH; count width log2(DEPTH)+1, range 0..DEPTH.
REQ-024 STATUS read: bit0 empty, bit1 full, bit2 overflow, bits[15:8] count, all other bits 0.
REQ-025 STATUS write: writedata bit2=1 clears overflow; other bits ignored. A set and a clear in the same cycle: set wins.
REQ-026 CONTROL read: bit0 0, bit1 irq_en, other bits 0.
REQ-027 CONTROL write: bit1 loads irq_en; bit0=1 flushes the FIFO (pointers and count to 0, out_valid=0 next cycle); a push or pop in the same cycle is discarded.
REQ-028 HELD read: held_key zero-extended to 32 bits. Writes to HELD SHALL be ignored.
REQ-029 DATA read SHALL return out_data zero-extended and SHALL NOT pop.
REQ-030 irq = irq_en AND overflow, registered-free combinational from those two flops.
REQ-031 Bits of writedata above DATA_WIDTH SHALL be ignored.

Reset
REQ-032 While reset=1 at a rising edge: FIFO empty, count 0, overflow 0, irq_en 0, held_key 0; out_valid=0, irq=0 from the next cycle.
REQ-033 Reset SHALL take priority over any simultaneous write, push or pop; FIFO storage contents need not be cleared.

Verification
REQ-034 Reset, then write DATA 0x1C -> next cycle out_valid=1, out_data=0x1C, held_key=0x1C, STATUS=0x0000_0100.
REQ-035 DEPTH=16, out_ready=0, write 17 keycodes 0x01..0x11 -> STATUS full=1, overflow=1, count=16; held_key=0x11; pops return 0x01..0x10 in order, then empty=1.
REQ-036 FIFO full, write DATA 0x2A with out_ready=1 the same cycle -> count stays 16, overflow 0, 0x2A last in sequence.
REQ-037 CONTROL write 0x2, then force overflow -> irq=1; STATUS write 0x4 -> irq=0 next cycle; CONTROL write 0x0 masks irq.
REQ-038 FIFO with 5 entries, CONTROL write 0x1 with concurrent pop -> next cycle count 0, out_valid=0; held_key unchanged.
REQ-039 Assert reset mid-stream with count=7 and overflow=1 -> next cycle STATUS=0x0000_0001, held_key=0, irq=0.

Source files
------------

// File: rtl/keycode_fifo_pio.sv
// Avalon-MM keycode mailbox: a first-word-fall-through FIFO with a sticky
// overflow flag, a held-key level output and a maskable overflow interrupt.
module keycode_fifo_pio #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] held_key,
  output logic                  irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_HELD    = 2'd3;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  overflow;
  logic                  irq_en;

  logic wr_cycle;
  logic push;
  logic pop;
  logic flush;
  logic full;
  logic empty;
  logic do_push;
  logic do_pop;
  logic set_ovf;
  logic clr_ovf;
  logic ctrl_wr;
  logic unused_writedata;

  // Bus decode and FIFO handshake qualification
  always_comb begin
    wr_cycle = chipselect && !write_n;
    push     = wr_cycle && (address == ADDR_DATA);
    ctrl_wr  = wr_cycle && (address == ADDR_CONTROL);
    clr_ovf  = wr_cycle && (address == ADDR_STATUS) && writedata[2];
    flush    = ctrl_wr && writedata[0];
    empty    = (count == '0);
    full     = (count == CW'(DEPTH));
    pop      = out_valid && out_ready;
    do_pop   = pop && !flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    do_push  = push && !flush && (!full || pop);
    set_ovf  = push && full && !pop;
  end

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      held_key <= '0;
    end else begin
      if (push) held_key <= writedata[DATA_WIDTH-1:0];
      if (ctrl_wr) irq_en <= writedata[1];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count_next;
      end
      if (set_ovf)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage is not reset; only the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= writedata[DATA_WIDTH-1:0];
  end

  assign out_data  = mem[rd_ptr];
  assign out_valid = !empty;
  assign irq       = irq_en && overflow;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(out_data);
      ADDR_STATUS:  readdata = {16'd0, 8'(count), 5'd0, overflow, full, empty};
      ADDR_CONTROL: readdata = {30'd0, irq_en, 1'b0};
      ADDR_HELD:    readdata = 32'(held_key);
      default:      readdata = '0;
    endcase
  end

  assign unused_writedata = ^writedata;

endmodule

// File: tb/tb_keycode_fifo_pio.sv
// Directed bench for keycode_fifo_pio: a vector table for single-cycle
// register behaviour plus sequences for fill/overflow, flush and reset.
module tb_keycode_fifo_pio;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  held_key;
  logic        irq;

  int errors = 0;
  int checks = 0;

  keycode_fifo_pio #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .held_key(held_key), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        rdy;
    logic [1:0]  raddr;
    logic [31:0] rd;
    logic        valid;
    logic [7:0]  dout;
    logic [7:0]  held;
    logic        irq;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one bus cycle across a rising edge, then return the bus to idle.
  task automatic cycle(input logic rst, input logic cs, input logic wn,
                       input logic [1:0] addr, input logic [31:0] wd, input logic rdy);
    @(negedge clk);
    reset = rst; chipselect = cs; write_n = wn; address = addr;
    writedata = wd; out_ready = rdy;
    @(posedge clk);
    #1;
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
    writedata = '0;
  endtask

  task automatic expect_all(input string name, input logic [1:0] raddr, input logic [31:0] rd,
                            input logic valid, input logic [7:0] dout,
                            input logic [7:0] held, input logic exp_irq);
    address = raddr;
    #1;
    chk($sformatf("%s.readdata[a%0d]", name, raddr), readdata, rd);
    chk($sformatf("%s.out_valid", name), 32'(out_valid), 32'(valid));
    if (valid) chk($sformatf("%s.out_data", name), 32'(out_data), 32'(dout));
    chk($sformatf("%s.held_key", name), 32'(held_key), 32'(held));
    chk($sformatf("%s.irq", name), 32'(irq), 32'(exp_irq));
  endtask

  function automatic logic [31:0] status(input int cnt, input logic ovf);
    return {16'd0, 8'(cnt), 5'd0, ovf, (cnt == 16), (cnt == 0)};
  endfunction

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0;
    writedata = '0; out_ready = 1'b0;

    //           rst cs wn addr wd             rdy raddr rd            vld dout   held   irq
    vecs[0]  = '{1'b1,1'b0,1'b1,2'd0,32'h0,        1'b0,2'd1,32'h0000_0001,1'b0,8'h00,8'h00,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,2'd0,32'h1C,       1'b0,2'd1,32'h0000_0100,1'b1,8'h1C,8'h1C,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,2'd0,32'h0,        1'b0,2'd0,32'h0000_001C,1'b1,8'h1C,8'h1C,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b1,2'd0,32'h0,        1'b0,2'd3,32'h0000_001C,1'b1,8'h1C,8'h1C,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b1,2'd0,32'h0,        1'b1,2'd1,32'h0000_0001,1'b0,8'h00,8'h1C,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,2'd2,32'h2,        1'b0,2'd2,32'h0000_0002,1'b0,8'h00,8'h1C,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,2'd0,32'hFFFF_FF55,1'b0,2'd0,32'h0000_0055,1'b1,8'h55,8'h55,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,2'd3,32'h77,       1'b0,2'd3,32'h0000_0055,1'b1,8'h55,8'h55,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b0,2'd1,32'h3,        1'b0,2'd1,32'h0000_0100,1'b1,8'h55,8'h55,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b0,2'd0,32'h66,       1'b1,2'd1,32'h0000_0100,1'b1,8'h66,8'h66,1'b0};
    vecs[10] = '{1'b0,1'b1,1'b0,2'd2,32'h3,        1'b1,2'd1,32'h0000_0001,1'b0,8'h00,8'h66,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,2'd0,32'h0,        1'b0,2'd2,32'h0000_0002,1'b0,8'h00,8'h66,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,2'd0,32'h99,       1'b0,2'd1,32'h0000_0001,1'b0,8'h00,8'h66,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b1,2'd0,32'h99,       1'b0,2'd3,32'h0000_0066,1'b0,8'h00,8'h66,1'b0};

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].rst, vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
      expect_all($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].rd, vecs[i].valid,
                 vecs[i].dout, vecs[i].held, vecs[i].irq);
    end

    // Fill to full with irq enabled, then overflow, mask/unmask and clear.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 2'd0, 32'(i), 1'b0);
      expect_all($sformatf("fill%0d", i), 2'd1, status(i, 1'b0), 1'b1, 8'h01, 8'(i), 1'b0);
    end
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 32'h11, 1'b0);
    expect_all("ovf", 2'd1, 32'h0000_1006, 1'b1, 8'h01, 8'h11, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 1'b0);
    expect_all("mask", 2'd1, 32'h0000_1006, 1'b1, 8'h01, 8'h11, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h2, 1'b0);
    expect_all("unmask", 2'd1, 32'h0000_1006, 1'b1, 8'h01, 8'h11, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 2'd1, 32'h4, 1'b0);
    expect_all("ovf_clr", 2'd1, 32'h0000_1002, 1'b1, 8'h01, 8'h11, 1'b0);

    // Push into a full FIFO while the head pops: no overflow, count holds.
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 32'h2A, 1'b1);
    expect_all("full_pushpop", 2'd1, 32'h0000_1002, 1'b1, 8'h02, 8'h2A, 1'b0);
    for (int k = 0; k < 16; k++) begin
      logic [7:0] head;
      head = (k < 15) ? 8'(k + 2) : 8'h2A;
      expect_all($sformatf("drain%0d", k), 2'd0, 32'(head), 1'b1, head, 8'h2A, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
    end
    expect_all("drained", 2'd1, 32'h0000_0001, 1'b0, 8'h00, 8'h2A, 1'b0);

    // Flush with a concurrent pop on a 5-entry FIFO.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 2'd0, 32'h31 + 32'(i), 1'b0);
    expect_all("five", 2'd1, status(5, 1'b0), 1'b1, 8'h31, 8'h35, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h3, 1'b1);
    expect_all("flush", 2'd1, 32'h0000_0001, 1'b0, 8'h00, 8'h35, 1'b0);
    expect_all("flush_ctl", 2'd2, 32'h0000_0002, 1'b0, 8'h00, 8'h35, 1'b0);

    // Reach count=7 with overflow set, then reset over a concurrent write.
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 1'b0, 2'd0, 32'h40 + 32'(i), 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
    expect_all("pre_rst", 2'd1, 32'h0000_0704, 1'b1, 8'h49, 8'h50, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 32'h77, 1'b1);
    expect_all("mid_rst", 2'd1, 32'h0000_0001, 1'b0, 8'h00, 8'h00, 1'b0);
    expect_all("rst_ctl", 2'd2, 32'h0000_0000, 1'b0, 8'h00, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
